// File: rtl/ac97_receiver.sv
// AC'97 serial input decoder: aligns to the frame sync, captures the tag,
// the codec status register pair (slots 1/2) and the left/right PCM pair
// (slots 3/4), and forwards PCM samples to a FIFO with overflow accounting.
module ac97_receiver #(
  parameter int OVF_W = 8
) (
  input  logic             bit_clk,
  input  logic             system_reset,
  input  logic             sync,
  input  logic             sdata_in,
  output logic [39:0]      sample_fifo_din,
  output logic             sample_fifo_wr_en,
  input  logic             sample_fifo_full,
  output logic [6:0]       status_addr,
  output logic [15:0]      status_data,
  output logic             status_valid,
  output logic             codec_ready,
  output logic             locked,
  output logic             frame_error,
  output logic [OVF_W-1:0] overflow_count
);

  typedef enum logic [1:0] {HUNT, TAG, SLOTS} state_t;

  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic             sync_prev_q, sync_prev_d;
  logic [38:0]      shift_q, shift_d;
  logic [3:0]       slot_valid_q, slot_valid_d;
  logic             codec_ready_q, codec_ready_d;
  logic             locked_q, locked_d;
  logic             frame_error_q, frame_error_d;
  logic             status_valid_q, status_valid_d;
  logic [6:0]       status_addr_q, status_addr_d;
  logic [15:0]      status_data_q, status_data_d;
  logic [39:0]      din_q, din_d;
  logic             wr_en_q, wr_en_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  logic             sync_rise;
  logic [39:0]      shift_next;

  assign sync_rise  = sync & ~sync_prev_q;
  assign shift_next = {shift_q, sdata_in};

  // Next-state: frame alignment, bit sampling and slot extraction at fixed bit positions
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    sync_prev_d    = sync;
    shift_d        = shift_q;
    slot_valid_d   = slot_valid_q;
    codec_ready_d  = codec_ready_q;
    locked_d       = locked_q;
    frame_error_d  = 1'b0;
    status_valid_d = 1'b0;
    status_addr_d  = status_addr_q;
    status_data_d  = status_data_q;
    din_d          = din_q;
    wr_en_d        = 1'b0;
    ovf_d          = ovf_q;
    case (state_q)
      HUNT: begin
        if (sync_rise) begin
          state_d   = TAG;
          bit_cnt_d = 8'd0;
        end
      end
      TAG, SLOTS: begin
        shift_d   = shift_next[38:0];
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (sync_rise) begin
          state_d   = TAG;
          bit_cnt_d = 8'd0;
          if (bit_cnt_q == 8'd255) begin
            locked_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
            locked_d      = 1'b0;
          end
        end else if (state_q == TAG) begin
          if (bit_cnt_q == 8'd15) begin
            state_d       = SLOTS;
            codec_ready_d = shift_next[15];
            slot_valid_d  = shift_next[14:11];
          end
        end else begin
          if (bit_cnt_q == 8'd255) begin
            state_d  = HUNT;
            locked_d = 1'b0;
          end
          if (bit_cnt_q == 8'd55 && slot_valid_q[3] && slot_valid_q[2]) begin
            status_valid_d = 1'b1;
            status_addr_d  = shift_next[38:32];
            status_data_d  = shift_next[19:4];
          end
          if (bit_cnt_q == 8'd95 && slot_valid_q[1] && slot_valid_q[0]) begin
            din_d = shift_next;
            if (sample_fifo_full) begin
              if (ovf_q != OVF_MAX) ovf_d = ovf_q + OVF_W'(1);
            end else begin
              wr_en_d = 1'b1;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and registered outputs, cleared asynchronously by system_reset
  always_ff @(posedge bit_clk or posedge system_reset) begin
    if (system_reset) begin
      state_q        <= HUNT;
      bit_cnt_q      <= '0;
      sync_prev_q    <= 1'b0;
      shift_q        <= '0;
      slot_valid_q   <= '0;
      codec_ready_q  <= 1'b0;
      locked_q       <= 1'b0;
      frame_error_q  <= 1'b0;
      status_valid_q <= 1'b0;
      status_addr_q  <= '0;
      status_data_q  <= '0;
      din_q          <= '0;
      wr_en_q        <= 1'b0;
      ovf_q          <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      sync_prev_q    <= sync_prev_d;
      shift_q        <= shift_d;
      slot_valid_q   <= slot_valid_d;
      codec_ready_q  <= codec_ready_d;
      locked_q       <= locked_d;
      frame_error_q  <= frame_error_d;
      status_valid_q <= status_valid_d;
      status_addr_q  <= status_addr_d;
      status_data_q  <= status_data_d;
      din_q          <= din_d;
      wr_en_q        <= wr_en_d;
      ovf_q          <= ovf_d;
    end
  end

  assign sample_fifo_din   = din_q;
  assign sample_fifo_wr_en = wr_en_q;
  assign status_addr       = status_addr_q;
  assign status_data       = status_data_q;
  assign status_valid      = status_valid_q;
  assign codec_ready       = codec_ready_q;
  assign locked            = locked_q;
  assign frame_error       = frame_error_q;
  assign overflow_count    = ovf_q;

endmodule

// File: tb/tb_ac97_receiver.sv
// Testbench for ac97_receiver: drives whole 256-bit frames built from a tag
// and slot values, and predicts decoder outputs frame by frame.
module tb_ac97_receiver;

  logic        bit_clk = 1'b0;
  logic        system_reset;
  logic        sync;
  logic        sdata_in;
  logic        sample_fifo_full;
  logic [39:0] sample_fifo_din;
  logic        sample_fifo_wr_en;
  logic [6:0]  status_addr;
  logic [15:0] status_data;
  logic        status_valid;
  logic        codec_ready;
  logic        locked;
  logic        frame_error;
  logic [7:0]  overflow_count;

  logic [39:0] b_din;
  logic        b_wr_en;
  logic [6:0]  b_addr;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic        b_locked;
  logic        b_error;
  logic [1:0]  b_ovf;

  ac97_receiver #(.OVF_W(8)) dut (
    .bit_clk(bit_clk), .system_reset(system_reset), .sync(sync), .sdata_in(sdata_in),
    .sample_fifo_din(sample_fifo_din), .sample_fifo_wr_en(sample_fifo_wr_en),
    .sample_fifo_full(sample_fifo_full), .status_addr(status_addr), .status_data(status_data),
    .status_valid(status_valid), .codec_ready(codec_ready), .locked(locked),
    .frame_error(frame_error), .overflow_count(overflow_count)
  );

  ac97_receiver #(.OVF_W(2)) dut2 (
    .bit_clk(bit_clk), .system_reset(system_reset), .sync(sync), .sdata_in(sdata_in),
    .sample_fifo_din(b_din), .sample_fifo_wr_en(b_wr_en),
    .sample_fifo_full(sample_fifo_full), .status_addr(b_addr), .status_data(b_data),
    .status_valid(b_valid), .codec_ready(b_ready), .locked(b_locked),
    .frame_error(b_error), .overflow_count(b_ovf)
  );

  always #5 bit_clk = ~bit_clk;

  int checks = 0;
  int failures = 0;

  // observed pulse history (bit index of the edge that produced each pulse)
  int lastIdx = -1;
  int svCount = 0, wrCount = 0, feCount = 0;
  int svAt = -1, wrAt = -1, feAt = -1;
  logic [6:0]  svAddr;
  logic [15:0] svData;
  logic [39:0] wrDin;

  // reference model state
  int          expSv = 0, expWr = 0, expFe = 0;
  logic        modelLocked = 1'b0;
  logic [6:0]  modelAddr = '0;
  logic [15:0] modelData = '0;
  logic [39:0] modelDin = '0;
  int          modelOvf = 0, modelOvf2 = 0;

  // Compare one observed value with its expected value and count it
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Record output pulses visible after the most recent rising edge
  task automatic observe();
    if (status_valid === 1'b1) begin
      svCount++; svAt = lastIdx; svAddr = status_addr; svData = status_data;
    end
    if (sample_fifo_wr_en === 1'b1) begin
      wrCount++; wrAt = lastIdx; wrDin = sample_fifo_din;
    end
    if (frame_error === 1'b1) begin
      feCount++; feAt = lastIdx;
    end
  endtask

  // One bit period: observe outputs, then drive sync/sdata for the next edge
  task automatic applyStimulus(input logic s, input logic d, input int idx);
    @(negedge bit_clk);
    observe();
    sync = s;
    sdata_in = d;
    lastIdx = idx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, ($urandom_range(0, 1) == 1), -1);
  endtask

  function automatic logic [255:0] makeFrame(input logic [15:0] tag, input logic [19:0] s1,
                                             input logic [19:0] s2, input logic [19:0] s3,
                                             input logic [19:0] s4);
    logic [255:0] f;
    f[255:240] = tag;
    f[239:220] = s1;
    f[219:200] = s2;
    f[199:180] = s3;
    f[179:160] = s4;
    for (int i = 0; i < 160; i++) f[i] = ($urandom_range(0, 1) == 1);
    return f;
  endfunction

  // frame bit i sits at f[255-i]; slot n spans bits 16+20(n-1) .. +19, MSB first
  function automatic logic [19:0] slotOf(input logic [255:0] f, input int n);
    logic [19:0] v;
    for (int k = 0; k < 20; k++) v[19-k] = f[255 - (16 + 20*(n-1) + k)];
    return v;
  endfunction

  function automatic logic [15:0] tagOf(input logic [255:0] f);
    logic [15:0] v;
    for (int k = 0; k < 16; k++) v[15-k] = f[255-k];
    return v;
  endfunction

  // Drive one frame (next edge samples bit 0). endMode: 255 = next sync rise
  // with bit 255, -1 = no following rise, 17..254 = sync rise (abort) at that bit.
  task automatic runFrame(input logic [255:0] f, input int endMode, input logic full);
    logic [15:0] tag;
    logic [19:0] s1, s2, s3, s4;
    int lastBit;
    logic svExp, pcm;
    tag = tagOf(f);
    s1 = slotOf(f, 1); s2 = slotOf(f, 2); s3 = slotOf(f, 3); s4 = slotOf(f, 4);
    lastBit = (endMode >= 17 && endMode <= 254) ? endMode : 255;
    sample_fifo_full = full;
    for (int i = 0; i <= lastBit; i++) begin
      logic s;
      if (i == lastBit && endMode != -1) s = 1'b1;
      else s = (i < 16);
      applyStimulus(s, f[255-i], i);
      if (i == 20) begin
        checkOutput("locked", {63'd0, locked}, {63'd0, modelLocked});
        checkOutput("frame_error count", feCount, expFe);
      end
    end
    svExp = tag[14] && tag[13] && (lastBit > 55);
    pcm   = tag[12] && tag[11] && (lastBit > 95);
    if (svExp) begin
      expSv++; modelAddr = s1[18:12]; modelData = s2[19:4];
    end
    if (pcm) begin
      modelDin = {s3, s4};
      if (full) begin
        if (modelOvf < 255) modelOvf++;
        if (modelOvf2 < 3) modelOvf2++;
      end else begin
        expWr++;
      end
    end
    checkOutput("status_valid count", svCount, expSv);
    if (svExp) begin
      checkOutput("status position", svAt, 55);
      checkOutput("status_addr at pulse", svAddr, modelAddr);
      checkOutput("status_data at pulse", svData, modelData);
    end
    checkOutput("wr_en count", wrCount, expWr);
    if (pcm && !full) begin
      checkOutput("wr_en position", wrAt, 95);
      checkOutput("din at write", wrDin, modelDin);
    end
    checkOutput("status_addr held", status_addr, modelAddr);
    checkOutput("status_data held", status_data, modelData);
    checkOutput("fifo_din held", sample_fifo_din, modelDin);
    checkOutput("codec_ready", {63'd0, codec_ready}, {63'd0, tag[15]});
    checkOutput("overflow_count", overflow_count, modelOvf);
    checkOutput("overflow_count OVF_W=2", b_ovf, modelOvf2);
    if (endMode == 255) modelLocked = 1'b1;
    else if (endMode == -1) modelLocked = 1'b0;
    else begin
      modelLocked = 1'b0;
      expFe++;
    end
  endtask

  task automatic checkAllZero(input string where);
    checkOutput({where, " fifo_din"}, sample_fifo_din, 0);
    checkOutput({where, " wr_en"}, {63'd0, sample_fifo_wr_en}, 0);
    checkOutput({where, " status_addr"}, status_addr, 0);
    checkOutput({where, " status_data"}, status_data, 0);
    checkOutput({where, " status_valid"}, {63'd0, status_valid}, 0);
    checkOutput({where, " codec_ready"}, {63'd0, codec_ready}, 0);
    checkOutput({where, " locked"}, {63'd0, locked}, 0);
    checkOutput({where, " frame_error"}, {63'd0, frame_error}, 0);
    checkOutput({where, " overflow_count"}, overflow_count, 0);
    checkOutput({where, " overflow_count OVF_W=2"}, b_ovf, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] f;
    int mode;
    system_reset = 1'b0;
    sync = 1'b0;
    sdata_in = 1'b0;
    sample_fifo_full = 1'b0;
    #2 system_reset = 1'b1;
    repeat (3) @(negedge bit_clk);
    checkAllZero("reset");
    system_reset = 1'b0;

    idle(8);
    checkOutput("idle status count", svCount, expSv);
    checkOutput("idle wr count", wrCount, expWr);

    $display("[TB] status frame and PCM frame");
    applyStimulus(1'b1, 1'b0, -1);
    runFrame(makeFrame(16'hF800, 20'h26000, 20'h0F0F0, 20'($urandom), 20'($urandom)), 255, 1'b0);
    checkOutput("status_addr value", status_addr, 7'h26);
    checkOutput("status_data value", status_data, 16'h0F0F);
    runFrame(makeFrame(16'h9800, 20'($urandom), 20'($urandom), 20'hABCDE, 20'h12345), 255, 1'b0);
    checkOutput("fifo_din value", sample_fifo_din, 40'hABCDE12345);

    $display("[TB] FIFO full frames");
    for (int n = 0; n < 5; n++) begin
      runFrame(makeFrame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 255, 1'b1);
      if (n == 2) checkOutput("overflow after 3", overflow_count, 3);
    end
    checkOutput("OVF_W=2 saturated", b_ovf, 2'd3);

    $display("[TB] tag without valid slots");
    runFrame(makeFrame(16'h7800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 255, 1'b0);
    runFrame(makeFrame(16'h8000, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 255, 1'b0);

    $display("[TB] misaligned sync");
    runFrame(makeFrame(16'h8000, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 100, 1'b0);
    runFrame(makeFrame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 255, 1'b0);
    checkOutput("frame_error position", feAt, 100);
    runFrame(makeFrame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 70, 1'b0);

    $display("[TB] random frames");
    for (int n = 0; n < 8; n++) begin
      mode = ($urandom_range(0, 2) == 0) ? int'($urandom_range(17, 254)) : 255;
      runFrame(makeFrame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)),
               mode, ($urandom_range(0, 1) == 1));
    end
    runFrame(makeFrame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 255, 1'b0);

    $display("[TB] reset in mid-frame");
    f = makeFrame(16'hF800, 20'h5A000, 20'h12340, 20'($urandom), 20'($urandom));
    for (int i = 0; i < 60; i++) applyStimulus(i < 16, f[255-i], i);
    @(negedge bit_clk);
    observe();
    expSv++;
    modelAddr = 7'h5A;
    modelData = 16'h1234;
    checkOutput("pre-reset status count", svCount, expSv);
    checkOutput("pre-reset status_addr", status_addr, modelAddr);
    checkOutput("pre-reset locked", {63'd0, locked}, 1);
    system_reset = 1'b1;
    #1;
    checkAllZero("async reset");
    modelAddr = '0; modelData = '0; modelDin = '0;
    modelOvf = 0; modelOvf2 = 0; modelLocked = 1'b0;
    repeat (2) @(negedge bit_clk);
    system_reset = 1'b0;
    for (int i = 60; i < 256; i++) applyStimulus(1'b0, f[255-i], -1);
    idle(6);
    checkOutput("post-reset status count", svCount, expSv);
    checkOutput("post-reset wr count", wrCount, expWr);
    checkOutput("post-reset codec_ready", {63'd0, codec_ready}, 0);
    checkOutput("post-reset fifo_din", sample_fifo_din, 0);
    applyStimulus(1'b1, 1'b0, -1);
    runFrame(makeFrame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), 255, 1'b0);
    runFrame(makeFrame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)), -1, 1'b0);
    idle(5);
    checkOutput("locked after lost sync", {63'd0, locked}, {63'd0, modelLocked});
    checkOutput("final frame_error count", feCount, expFe);
    checkOutput("final status count", svCount, expSv);
    checkOutput("final wr count", wrCount, expWr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
